// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: synchronizes and debounces the board buttons/switch and runs the
// RUN/PAUSED/ADJUST controller that drives the digit counter's hold, clear and adjust controls.
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned ADJ_DIV         = 20000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       btn_sel,
    input  logic       sw_adj,
    output logic       paused,
    output logic       clr,
    output logic       adj,
    output logic [2:0] adj_sel,
    output logic [3:0] adj_val,
    output logic       adj_we
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned STEP_W = $clog2(ADJ_DIV);
    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(ADJ_DIV - 1);

    typedef enum logic [1:0] {StPaused, StRun, StAdjust} state_t;

    state_t            state, state_d;
    logic [3:0]        raw, sync1, sync2, db;
    logic [2:0]        db_prev, press;
    logic [DB_W-1:0]   db_cnt [4];
    logic [STEP_W-1:0] step;
    logic              pause_press, rst_press, sel_press, adj_lvl;
    logic [3:0]        adj_lim;

    // Bit order: 0 pause, 1 reset, 2 select, 3 adjust switch.
    assign raw = {sw_adj, btn_sel, btn_reset, btn_pause};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            db_prev <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            db_prev <= db[2:0];
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign press       = db[2:0] & ~db_prev;
    assign pause_press = press[0];
    assign rst_press   = press[1];
    assign sel_press   = press[2];
    assign adj_lvl     = db[3];
    assign adj_lim     = (adj_sel[1:0] == 2'd2) ? 4'd5 : 4'd9;

    // A clear press swallows a same-cycle pause press; the switch outranks both.
    always_comb begin
        state_d = state;
        case (state)
            StPaused: begin
                if (adj_lvl) state_d = StAdjust;
                else if (pause_press && !rst_press) state_d = StRun;
            end
            StRun: begin
                if (adj_lvl) state_d = StAdjust;
                else if (pause_press && !rst_press) state_d = StPaused;
            end
            StAdjust: begin
                if (!adj_lvl) state_d = StPaused;
            end
            default: state_d = StPaused;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StPaused;
            paused  <= 1'b1;
            clr     <= 1'b0;
            adj     <= 1'b0;
            adj_sel <= 3'd0;
            adj_val <= 4'd0;
            adj_we  <= 1'b0;
            step    <= '0;
        end else begin
            state  <= state_d;
            paused <= (state_d != StRun);
            adj    <= (state_d == StAdjust);
            clr    <= rst_press;
            adj_we <= 1'b0;
            step   <= '0;
            if (state_d == StAdjust) begin
                if (state != StAdjust) begin
                    adj_sel <= 3'd0;
                    adj_val <= 4'd0;
                end else if (rst_press) begin
                    adj_val <= 4'd0;
                end else if (sel_press) begin
                    adj_sel <= {1'b0, adj_sel[1:0] + 2'd1};
                    adj_val <= 4'd0;
                end else if (step == STEP_MAX) begin
                    adj_val <= (adj_val == adj_lim) ? 4'd0 : adj_val + 4'd1;
                    adj_we  <= 1'b1;
                end else begin
                    step <= step + STEP_W'(1);
                end
            end else if (state == StAdjust && rst_press) begin
                adj_val <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with short debounce and step periods.
module tb_stopwatch_ctrl;

    logic       clk, rst;
    logic       btn_pause, btn_reset, btn_sel, sw_adj;
    logic       paused, clr, adj, adj_we;
    logic [2:0] adj_sel;
    logic [3:0] adj_val;

    int n_checks = 0;
    int n_errors = 0;

    // Event monitor, restarted by start_watch; cyc counts clock edges since the restart.
    int   cyc, p_chg, p_at, clr_n, clr_at, we_n, bad;
    int   we_vals [16];
    logic prev_paused;

    int exp_run [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_sec [7]  = '{1, 2, 3, 4, 5, 0, 1};

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .ADJ_DIV        (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_pause(btn_pause),
        .btn_reset(btn_reset),
        .btn_sel  (btn_sel),
        .sw_adj   (sw_adj),
        .paused   (paused),
        .clr      (clr),
        .adj      (adj),
        .adj_sel  (adj_sel),
        .adj_val  (adj_val),
        .adj_we   (adj_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_watch();
        cyc         = 0;
        p_chg       = 0;
        p_at        = -1;
        clr_n       = 0;
        clr_at      = -1;
        we_n        = 0;
        prev_paused = paused;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (paused != prev_paused) begin
            p_chg++;
            if (p_at < 0) p_at = cyc;
        end
        prev_paused = paused;
        if (clr) begin
            clr_n++;
            if (clr_at < 0) clr_at = cyc;
        end
        if (adj_we) begin
            if (we_n < 16) we_vals[we_n] = adj_val;
            we_n++;
        end
    endtask

    // Hold the given buttons {sel, reset, pause} for 20 cycles, then release and settle.
    task automatic hold(input logic [2:0] btns);
        start_watch();
        {btn_sel, btn_reset, btn_pause} = btns;
        repeat (20) tick();
        {btn_sel, btn_reset, btn_pause} = 3'b000;
        repeat (10) tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_paused"}, paused, 1);
        check({tag, "_adj"}, adj, 0);
        check({tag, "_sel"}, adj_sel, 0);
        check({tag, "_val"}, adj_val, 0);
        check({tag, "_clr"}, clr, 0);
        check({tag, "_we"}, adj_we, 0);
    endtask

    initial begin
        rst = 1'b0;
        {btn_pause, btn_reset, btn_sel, sw_adj} = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("in_reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Short bounce must be rejected.
        start_watch();
        btn_pause = 1'b1;
        repeat (3) tick();
        btn_pause = 1'b0;
        repeat (12) tick();
        check("bounce_chg", p_chg, 0);
        check("bounce_paused", paused, 1);

        hold(3'b001);
        check("run_lat", p_at, 7);
        check("run_chg", p_chg, 1);
        check("run_paused", paused, 0);

        hold(3'b001);
        check("pause_lat", p_at, 7);
        check("pause_paused", paused, 1);

        hold(3'b001);
        check("run2_paused", paused, 0);

        hold(3'b010);
        check("clr_lat", clr_at, 7);
        check("clr_cnt", clr_n, 1);
        check("clr_pchg", p_chg, 0);

        hold(3'b011);
        check("both_clr_cnt", clr_n, 1);
        check("both_pchg", p_chg, 0);
        check("both_paused", paused, 0);

        // Reset asserted while running.
        rst = 1'b0;
        #3;
        check_reset_vals("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("post_reset");

        // Enter adjust and let it step.
        start_watch();
        sw_adj = 1'b1;
        while (!adj && cyc < 20) tick();
        check("adj_lat", cyc, 7);
        check("adj_entry_paused", paused, 1);
        check("adj_entry_sel", adj_sel, 0);
        check("adj_entry_val", adj_val, 0);
        check("adj_entry_we", adj_we, 0);
        start_watch();
        bad = 0;
        repeat (125) begin
            tick();
            if (!paused || !adj) bad++;
        end
        check("adj_flags", bad, 0);
        check("adj_we_cnt", we_n, 12);
        for (int i = 0; i < 12 && i < we_n; i++) check("adj_seq", we_vals[i], exp_run[i]);

        // Two select presses land on the seconds-tens digit.
        start_watch();
        btn_sel = 1'b1;
        while (adj_sel == 3'd0 && cyc < 20) tick();
        check("sel1_lat", cyc, 7);
        check("sel1_val", adj_val, 0);
        btn_sel = 1'b0;
        repeat (8) tick();
        start_watch();
        btn_sel = 1'b1;
        while (adj_sel != 3'd2 && cyc < 20) tick();
        check("sel2_sel", adj_sel, 2);
        check("sel2_val", adj_val, 0);
        check("sel2_we", adj_we, 0);
        btn_sel = 1'b0;
        start_watch();
        repeat (70) tick();
        check("sec_we_cnt", we_n, 7);
        for (int i = 0; i < 7 && i < we_n; i++) check("sec_seq", we_vals[i], exp_sec[i]);

        // Step counter is now 0; time a select press onto the next wrap edge.
        repeat (3) tick();
        btn_sel = 1'b1;
        start_watch();
        repeat (7) tick();
        check("coin_sel", adj_sel, 3);
        check("coin_val", adj_val, 0);
        check("coin_we_cnt", we_n, 0);
        btn_sel = 1'b0;
        repeat (8) tick();

        // Leave adjust; one step lands at +2 before exit, so value 1 is held.
        start_watch();
        sw_adj = 1'b0;
        while (adj && cyc < 20) tick();
        check("exit_lat", cyc, 7);
        check("exit_paused", paused, 1);
        check("exit_sel", adj_sel, 3);
        check("exit_val", adj_val, 1);

        hold(3'b100);
        check("ign_sel", adj_sel, 3);
        check("ign_val", adj_val, 1);
        check("ign_we_cnt", we_n, 0);
        check("ign_adj", adj, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Button and switch front end for the stopwatch, sitting directly upstream of the digit counter. It synchronizes and debounces the raw board inputs and runs a RUN/PAUSED/ADJUST state machine. It drives the counter's `paused`, clear, adjust-mode, digit-select and digit-value controls. During ADJUST it auto-steps the selected digit at a fixed rate.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a synchronized input is accepted (≥2).
- `ADJ_DIV`, default 20000000: cycles between auto-increments of `adj_val` in ADJUST (≥2).

Ports:
- `clk` in 1: system clock; only clock.
- `rst` in 1: asynchronous, active-low reset.
- `btn_pause` in 1: raw pause/resume button, active-high, asynchronous.
- `btn_reset` in 1: raw clear button, active-high, asynchronous.
- `btn_sel` in 1: raw digit-select button, active-high, asynchronous.
- `sw_adj` in 1: raw adjust-mode switch, level, asynchronous.
- `paused` out 1: counter hold; high in PAUSED and ADJUST.
- `clr` out 1: one-cycle pulse that zeroes all counter digits.
- `adj` out 1: high while in ADJUST.
- `adj_sel` out 3: digit index (0=min_l, 1=min_r, 2=sec_l, 3=sec_r). Bit 2 is always 0.
- `adj_val` out 4: value for the selected digit.
- `adj_we` out 1: one-cycle pulse; counter loads `adj_val` into digit `adj_sel`.

## Operation
Input conditioning, applied identically to all four inputs:
- Each input passes through a 2-flop synchronizer.
- Each has a debounced level `db`, reset to 0. `db` takes the synchronized value after that value has differed from `db` for `DEBOUNCE_CYCLES` consecutive cycles.
- Any sample equal to `db` restarts that input's stability count.
- A button "press" is a one-cycle internal pulse on the cycle after its `db` rises. Releases generate nothing.
- `sw_adj` is used as its `db` level.

State machine, resetting to PAUSED:
- **PAUSED**
  - pause press → RUN.
  - `db(sw_adj)`=1 → ADJUST.
- **RUN**
  - pause press → PAUSED.
  - `db(sw_adj)`=1 → ADJUST.
- **ADJUST**
  - `db(sw_adj)`=0 → PAUSED.
  - Pause presses are ignored.
- The `sw_adj` transition has priority over a same-cycle pause press.

Output decode:
- `paused` = (state != RUN).
- `adj` = (state == ADJUST).

Reset press, valid in any state:
- `clr` is high for exactly one cycle.
- A pause press in the same cycle is discarded, so the state is unchanged.
- In ADJUST, `adj_val` is also set to 0 and the step counter is cleared.

ADJUST datapath:
- On entry to ADJUST: `adj_sel`=0, `adj_val`=0, step counter=0, no `adj_we`.
- Step counter counts 0..`ADJ_DIV`-1. On wrap, `adj_val` increments and `adj_we` pulses.
- Wrap limit is 9 for `adj_sel` 0, 1, 3 and 5 for `adj_sel` 2. Past the limit `adj_val` wraps to 0.
- Select press:
  - `adj_sel` = (`adj_sel`+1) mod 4.
  - `adj_val`=0 and the step counter clears.
  - No `adj_we`.
  - Select press beats a same-cycle step.
- Reset press beats both select and step.
- Outside ADJUST:
  - The step counter is held at 0.
  - `adj_we`=0.
  - `adj_sel` and `adj_val` hold their last values.
  - Select presses are ignored.

## Timing
Values during reset: `paused`=1; `clr`, `adj`, `adj_sel`, `adj_val`, `adj_we` all 0; every `db` and stability counter at 0.

Reset deassertion mid-operation: all state restarts from the reset values. No pending press survives.

Latency from an input edge that is held stable:
- The internal press or `db` change occurs `DEBOUNCE_CYCLES`+2 cycles after the edge.
- Registered outputs (`paused`, `adj`, `clr`) change one cycle later, i.e. L = `DEBOUNCE_CYCLES`+3 cycles.
- Bounce shorter than `DEBOUNCE_CYCLES` cycles produces no press.

`adj_we` and the new `adj_val`:
- Both appear on the same clock edge, so the counter samples a consistent pair.
- The first step occurs `ADJ_DIV` cycles after ADJUST entry or after the last select/reset press.

A held button generates exactly one press.

All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `ADJ_DIV`=10.

- **Reset values:** drive `rst`=0 mid-run, then release. Outputs must read `paused`=1, `adj`=0, `adj_sel`=0, `adj_val`=0, `clr`=0, `adj_we`=0.
- **Pause toggle and bounce rejection:**
  - Pulse `btn_pause` high for 3 cycles → no change.
  - Hold `btn_pause` high for 20 cycles → `paused` goes 1→0 exactly 7 cycles after the edge, once.
  - A second hold → `paused`=1.
- **Clear:** hold `btn_reset` in RUN → `clr` is high for one cycle 7 cycles after the edge, and `paused` stays 0.
  - Pause and reset held simultaneously → one `clr`, and `paused` is unchanged.
- **Adjust stepping:** set `sw_adj`=1 and hold for 125 cycles after entry.
  - Must see 12 `adj_we` pulses.
  - `adj_val` sequence: 1..9, 0, 1, 2.
  - `paused`=1 and `adj`=1 throughout.
- **Select and limit:** in ADJUST, press select twice → `adj_sel`=2 and `adj_val`=0.
  - Run 70 cycles → `adj_val` sequence 1..5, 0, 1.
  - A select press coinciding with a step wrap → `adj_sel`=3, `adj_val`=0, no `adj_we`.
- **Exit adjust:** set `sw_adj`=0 → state PAUSED after 7 cycles: `adj`=0, `paused`=1, `adj_sel` and `adj_val` held.
  - Select presses are then ignored.
